// File: rtl/bcd_scan_display.sv
// Binary-to-BCD converter (sequential double-dabble) driving a multiplexed active-low 7-segment display.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module bcd_scan_display #(
  parameter int DATA_W      = 4,
  parameter int NDIG        = 2,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic              dp_n
);

  localparam int BCD_W = 4 * NDIG;
  localparam int SR_W  = BCD_W + DATA_W;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if (10**NDIG <= 2**DATA_W) begin : g_ndig_too_small
      $error("bcd_scan_display: NDIG too small to hold 2**DATA_W-1 in decimal");
    end
    if (DATA_W < 1 || DATA_W > 8) begin : g_data_w_range
      $error("bcd_scan_display: DATA_W must be 1..8");
    end
    if (REFRESH_DIV < 2) begin : g_refresh_range
      $error("bcd_scan_display: REFRESH_DIV must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             r_state, w_state_next;
  logic [DATA_W-1:0]  r_shadow, w_shadow_next;
  logic [SR_W-1:0]    r_shift, w_shift_next, w_adj;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic               r_busy, w_busy_next;
  logic [BCD_W-1:0]   r_bcd, w_bcd_next;

  logic [PRE_W-1:0]   r_presc;
  logic [IDX_W-1:0]   r_idx;
  logic [6:0]         r_seg, w_seg_next;
  logic [NDIG-1:0]    r_an, w_an_next;
  logic [3:0]         w_digit [NDIG];
  logic [NDIG-1:0]    w_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_bcd    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_shadow <= w_shadow_next;
      r_shift  <= w_shift_next;
      r_cnt    <= w_cnt_next;
      r_busy   <= w_busy_next;
      r_bcd    <= w_bcd_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_shadow_next = r_shadow;
    w_shift_next  = r_shift;
    w_cnt_next    = r_cnt;
    w_busy_next   = r_busy;
    w_bcd_next    = r_bcd;
    // Add-3 correction on every BCD nibble before the shift
    w_adj = r_shift;
    for (int k = 0; k < NDIG; k++) begin
      if (r_shift[DATA_W + 4*k +: 4] >= 4'd5)
        w_adj[DATA_W + 4*k +: 4] = r_shift[DATA_W + 4*k +: 4] + 4'd3;
    end
    case (r_state)
      S_IDLE: begin
        if (din != r_shadow) begin
          w_shadow_next = din;
          w_shift_next  = {{BCD_W{1'b0}}, din};
          w_cnt_next    = '0;
          w_busy_next   = 1'b1;
          w_state_next  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_shift_next = w_adj << 1;
        w_cnt_next   = r_cnt + 1'b1;
        if (r_cnt == CNT_W'(DATA_W - 1))
          w_state_next = S_DONE;
      end
      S_DONE: begin
        w_bcd_next   = r_shift[SR_W-1 -: BCD_W];
        w_busy_next  = 1'b0;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_digit
      assign w_digit[gi]   = r_bcd[4*gi +: 4];
      assign w_an_next[gi] = (r_idx != IDX_W'(gi));
`ifdef SEG_LZB_EN
      if (gi == 0) begin : g_units
        assign w_blank[gi] = 1'b0;
      end else begin : g_upper
        // Blank when this digit and every digit above it are zero
        assign w_blank[gi] = (r_bcd[BCD_W-1:4*gi] == '0);
      end
`else
      assign w_blank[gi] = 1'b0;
`endif
    end
  endgenerate

  assign w_seg_next = w_blank[r_idx] ? 7'h7F : seg_decode(w_digit[r_idx]);

  // Scan runs freely; conversion activity never stalls it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_seg   <= 7'h7F;
      r_an    <= '1;
    end else begin
      if (r_presc == PRE_W'(REFRESH_DIV - 1)) begin
        r_presc <= '0;
        r_idx   <= (r_idx == IDX_W'(NDIG - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
    end
  end

  assign busy = r_busy;
  assign seg  = r_seg;
  assign an   = r_an;
  assign dp_n = 1'b1;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed self-checking bench for bcd_scan_display (DATA_W=4, NDIG=2, REFRESH_DIV=4).
module tb_bcd_scan_display;

`ifdef SEG_LZB_EN
  localparam logic [6:0] TENS_ZERO = 7'h7F;
`else
  localparam logic [6:0] TENS_ZERO = 7'h40;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] din = 4'd0;
  logic       busy;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dp_n;

  int checks = 0;
  int errors = 0;

  bcd_scan_display #(.DATA_W(4), .NDIG(2), .REFRESH_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .busy  (busy),
    .seg   (seg),
    .an    (an),
    .dp_n  (dp_n)
  );

  always #5 clk = ~clk;

  // Advance until the requested anode pattern is active (bounded)
  task automatic wait_an(input logic [1:0] want, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (an === want) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    din = 4'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (an !== 2'b11) begin errors++; $display("FAIL reset_an got %b want %b", an, 2'b11); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h want %h", seg, 7'h7F); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want %b", busy, 1'b0); end
    checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL reset_dp got %b want %b", dp_n, 1'b1); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (an !== 2'b10) begin errors++; $display("FAIL release_an got %b want %b", an, 2'b10); end
    checks++; if (seg !== 7'h40) begin errors++; $display("FAIL release_seg got %h want %h", seg, 7'h40); end
    $display("test_reset done");
  endtask

  task automatic test_scan;
    logic [1:0] exp_an;
    logic [6:0] exp_seg;
    for (int n = 2; n <= 17; n++) begin
      @(posedge clk); #1;
      exp_an  = (((n - 1) / 4) % 2 == 1) ? 2'b01 : 2'b10;
      exp_seg = (((n - 1) / 4) % 2 == 1) ? TENS_ZERO : 7'h40;
      checks++; if (an !== exp_an) begin errors++; $display("FAIL scan_an edge %0d got %b want %b", n, an, exp_an); end
      checks++; if (seg !== exp_seg) begin errors++; $display("FAIL scan_seg edge %0d got %h want %h", n, seg, exp_seg); end
    end
    $display("test_scan done");
  endtask

  task automatic test_convert_13;
    bit ok;
    din = 4'd13;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      checks++;
      if (busy !== (i < 5)) begin errors++; $display("FAIL conv13_busy cycle %0d got %b want %b", i, busy, (i < 5)); end
    end
    @(posedge clk); #1;
    wait_an(2'b10, ok);
    checks++; if (!ok || seg !== 7'h30) begin errors++; $display("FAIL conv13_units got %h want %h", seg, 7'h30); end
    wait_an(2'b01, ok);
    checks++; if (!ok || seg !== 7'h79) begin errors++; $display("FAIL conv13_tens got %h want %h", seg, 7'h79); end
    $display("test_convert_13 done");
  endtask

  task automatic test_mid_change;
    bit ok;
    int hi;
    hi = 0;
    din = 4'd5;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (i == 1) din = 4'd9;
      if (busy === 1'b1) hi++;
    end
    checks++; if (hi != 10) begin errors++; $display("FAIL mid_busy_cycles got %0d want %0d", hi, 10); end
    wait_an(2'b10, ok);
    checks++; if (!ok || seg !== 7'h10) begin errors++; $display("FAIL mid_units got %h want %h", seg, 7'h10); end
    wait_an(2'b01, ok);
    checks++; if (!ok || seg !== TENS_ZERO) begin errors++; $display("FAIL mid_tens got %h want %h", seg, TENS_ZERO); end
    $display("test_mid_change done");
  endtask

  task automatic test_reset_mid;
    bit ok;
    din = 4'd12;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want %b", busy, 1'b0); end
    checks++; if (an !== 2'b11) begin errors++; $display("FAIL rmid_an got %b want %b", an, 2'b11); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL rmid_seg got %h want %h", seg, 7'h7F); end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        checks++; if (an !== 2'b10) begin errors++; $display("FAIL rmid_post_an got %b want %b", an, 2'b10); end
        checks++; if (seg !== 7'h40) begin errors++; $display("FAIL rmid_post_units got %h want %h", seg, 7'h40); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_reconv_busy got %b want %b", busy, 1'b1); end
      end
      if (n == 5) begin
        checks++; if (an !== 2'b01) begin errors++; $display("FAIL rmid_post_an5 got %b want %b", an, 2'b01); end
        checks++; if (seg !== TENS_ZERO) begin errors++; $display("FAIL rmid_post_tens got %h want %h", seg, TENS_ZERO); end
      end
    end
    repeat (2) @(posedge clk);
    #1;
    wait_an(2'b10, ok);
    checks++; if (!ok || seg !== 7'h24) begin errors++; $display("FAIL rmid_units12 got %h want %h", seg, 7'h24); end
    wait_an(2'b01, ok);
    checks++; if (!ok || seg !== 7'h79) begin errors++; $display("FAIL rmid_tens12 got %h want %h", seg, 7'h79); end
    $display("test_reset_mid done");
  endtask

  task automatic test_lzb;
    bit ok;
    din = 4'd5;
    repeat (8) @(posedge clk);
    #1;
    wait_an(2'b01, ok);
    checks++; if (!ok || seg !== TENS_ZERO) begin errors++; $display("FAIL lzb_tens5 got %h want %h", seg, TENS_ZERO); end
    wait_an(2'b10, ok);
    checks++; if (!ok || seg !== 7'h12) begin errors++; $display("FAIL lzb_units5 got %h want %h", seg, 7'h12); end
    din = 4'd0;
    repeat (8) @(posedge clk);
    #1;
    wait_an(2'b10, ok);
    checks++; if (!ok || seg !== 7'h40) begin errors++; $display("FAIL lzb_units0 got %h want %h", seg, 7'h40); end
    wait_an(2'b01, ok);
    checks++; if (!ok || seg !== TENS_ZERO) begin errors++; $display("FAIL lzb_tens0 got %h want %h", seg, TENS_ZERO); end
    $display("test_lzb done");
  endtask

  task automatic test_back_to_back;
    bit ok;
    for (int v = 1; v <= 15; v++) begin
      din = 4'(v);
      @(posedge clk); #1;
    end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b want %b", busy, 1'b0); end
    wait_an(2'b10, ok);
    checks++; if (!ok || seg !== 7'h12) begin errors++; $display("FAIL b2b_units got %h want %h", seg, 7'h12); end
    wait_an(2'b01, ok);
    checks++; if (!ok || seg !== 7'h79) begin errors++; $display("FAIL b2b_tens got %h want %h", seg, 7'h79); end
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset;
    test_scan;
    test_convert_13;
    test_mid_change;
    test_reset_mid;
    test_lzb;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
